// File: rtl/ex_stage.sv
// Execute stage: ALU, optional multi-cycle divider, data SRAM request and bypass.
// Define EX_DIV_EN to build the radix-2 restoring divider; otherwise div results read as 0.
module ex_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ID_to_EX_valid,
  output logic        EX_allow_in,
  input  logic [3:0]  alu_op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        div_en,
  input  logic [1:0]  div_op,
  input  logic [4:0]  ld_ctrl,
  input  logic [2:0]  st_ctrl,
  input  logic [31:0] rkd_value,
  input  logic        rf_we,
  input  logic        res_from_mem,
  input  logic [4:0]  rf_waddr,
  input  logic [31:0] pc,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_we,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        MEM_allow_in,
  output logic        EXreg_valid,
  output logic [31:0] EX_result,
  output logic [4:0]  EXreg_ld_ctrl,
  output logic        EXreg_rf_we,
  output logic        EXreg_res_from_mem,
  output logic [4:0]  EXreg_rf_waddr,
  output logic [31:0] EXreg_pc,
  output logic [4:0]  EX_bypass_waddr,
  output logic        EX_bypass_we,
  output logic [31:0] EX_bypass_result,
  output logic        EX_is_load
);
  typedef struct packed {
    logic [3:0]  alu_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        div_en;
    logic [1:0]  div_op;   // {signed, want_remainder}
    logic [4:0]  ld_ctrl;  // {ld_w, ld_b, ld_bu, ld_h, ld_hu}
    logic [2:0]  st_ctrl;  // {st_w, st_h, st_b}
    logic [31:0] rkd;
    logic        rf_we;
    logic        res_from_mem;
    logic [4:0]  rf_waddr;
    logic [31:0] pc;
  } ex_fields_t;

  logic       valid_q, valid_d;
  ex_fields_t fld_q, fld_d;
  logic       ready_go;
  logic [31:0] alu_res, div_res;
  logic [4:0]  shamt;

  assign EX_allow_in = ~valid_q | (ready_go & MEM_allow_in);

  always_comb begin
    valid_d = valid_q;
    fld_d   = fld_q;
    if (EX_allow_in) begin
      valid_d = ID_to_EX_valid;
      if (ID_to_EX_valid)
        fld_d = '{alu_op, src1, src2, div_en, div_op, ld_ctrl, st_ctrl,
                  rkd_value, rf_we, res_from_mem, rf_waddr, pc};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      fld_q   <= '0;
    end else begin
      valid_q <= valid_d;
      fld_q   <= fld_d;
    end
  end

  assign shamt = fld_q.src2[4:0];

  always_comb begin
    alu_res = '0;
    case (fld_q.alu_op)
      4'd0:  alu_res = fld_q.src1 + fld_q.src2;
      4'd1:  alu_res = fld_q.src1 - fld_q.src2;
      4'd2:  alu_res = {31'b0, $signed(fld_q.src1) < $signed(fld_q.src2)};
      4'd3:  alu_res = {31'b0, fld_q.src1 < fld_q.src2};
      4'd4:  alu_res = fld_q.src1 & fld_q.src2;
      4'd5:  alu_res = fld_q.src1 | fld_q.src2;
      4'd6:  alu_res = ~(fld_q.src1 | fld_q.src2);
      4'd7:  alu_res = fld_q.src1 ^ fld_q.src2;
      4'd8:  alu_res = fld_q.src1 << shamt;
      4'd9:  alu_res = fld_q.src1 >> shamt;
      4'd10: alu_res = $signed(fld_q.src1) >>> shamt;
      4'd11: alu_res = fld_q.src2;
      default: alu_res = '0;
    endcase
  end

`ifdef EX_DIV_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;
  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [32:0] shl, diff;
  logic        sgn;
  logic [31:0] q_fix, r_fix;

  assign sgn = fld_q.div_op[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    // Partial remainder shifted left with the next dividend bit from quo_q's MSB.
    shl  = {rem_q, quo_q[31]};
    diff = shl - {1'b0, dvs_q};
    case (state_q)
      IDLE: if (valid_q && fld_q.div_en) begin
        state_d = BUSY;
        cnt_d   = '0;
        rem_d   = '0;
        quo_d   = (sgn && fld_q.src1[31]) ? -fld_q.src1 : fld_q.src1;
        dvs_d   = (sgn && fld_q.src2[31]) ? -fld_q.src2 : fld_q.src2;
      end
      BUSY: begin
        cnt_d = cnt_q + 5'd1;
        if (!diff[32]) begin
          rem_d = diff[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = shl[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        if (cnt_q == 5'd31) state_d = DONE;
      end
      DONE: if (valid_q && MEM_allow_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
    end
  end

  always_comb begin
    q_fix = (sgn && (fld_q.src1[31] ^ fld_q.src2[31])) ? -quo_q : quo_q;
    r_fix = (sgn && fld_q.src1[31]) ? -rem_q : rem_q;
    if (fld_q.src2 == '0) begin
      q_fix = '1;
      r_fix = fld_q.src1;
    end
    div_res = fld_q.div_op[0] ? r_fix : q_fix;
  end

  assign ready_go = ~fld_q.div_en | (state_q == DONE);
`else
  logic [1:0] unused_div_op;
  assign unused_div_op = fld_q.div_op;
  assign div_res  = '0;
  assign ready_go = 1'b1;
`endif

  assign EX_result          = fld_q.div_en ? div_res : alu_res;
  assign EXreg_valid        = valid_q & ready_go;
  assign EXreg_ld_ctrl      = fld_q.ld_ctrl;
  assign EXreg_rf_we        = fld_q.rf_we;
  assign EXreg_res_from_mem = fld_q.res_from_mem;
  assign EXreg_rf_waddr     = fld_q.rf_waddr;
  assign EXreg_pc           = fld_q.pc;

  assign data_sram_en   = valid_q & ready_go & MEM_allow_in & (|fld_q.ld_ctrl | |fld_q.st_ctrl);
  assign data_sram_addr = alu_res;

  always_comb begin
    data_sram_we    = 4'b0000;
    data_sram_wdata = fld_q.rkd;
    if (fld_q.st_ctrl[2]) begin
      data_sram_we = 4'b1111;
    end else if (fld_q.st_ctrl[1]) begin
      data_sram_we    = 4'b0011 << {alu_res[1], 1'b0};
      data_sram_wdata = {2{fld_q.rkd[15:0]}};
    end else if (fld_q.st_ctrl[0]) begin
      data_sram_we    = 4'b0001 << alu_res[1:0];
      data_sram_wdata = {4{fld_q.rkd[7:0]}};
    end
  end

  assign EX_bypass_we     = valid_q & fld_q.rf_we;
  assign EX_bypass_waddr  = fld_q.rf_waddr;
  assign EX_bypass_result = EX_result;
  assign EX_is_load       = valid_q & fld_q.res_from_mem;
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed literal cases plus random traffic against a behavioural model.
module tb_ex_stage;
  typedef struct packed {
    logic [3:0]  alu_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        div_en;
    logic [1:0]  div_op;
    logic [4:0]  ld;
    logic [2:0]  st;
    logic [31:0] rkd;
    logic        rf_we;
    logic        rfm;
    logic [4:0]  waddr;
    logic [31:0] pc;
  } inst_t;

`ifdef EX_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic clk = 1'b0, resetn = 1'b0, id_valid = 1'b0, mem_allow = 1'b1;
  inst_t cur = '0;
  logic        allow_in, sram_en, exreg_valid, exreg_rf_we, exreg_rfm, byp_we, is_load;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr, sram_wdata, ex_result, exreg_pc, byp_result;
  logic [4:0]  exreg_ld, exreg_waddr, byp_waddr;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .resetn(resetn), .ID_to_EX_valid(id_valid), .EX_allow_in(allow_in),
    .alu_op(cur.alu_op), .src1(cur.src1), .src2(cur.src2), .div_en(cur.div_en),
    .div_op(cur.div_op), .ld_ctrl(cur.ld), .st_ctrl(cur.st), .rkd_value(cur.rkd),
    .rf_we(cur.rf_we), .res_from_mem(cur.rfm), .rf_waddr(cur.waddr), .pc(cur.pc),
    .data_sram_en(sram_en), .data_sram_we(sram_we), .data_sram_addr(sram_addr),
    .data_sram_wdata(sram_wdata), .MEM_allow_in(mem_allow), .EXreg_valid(exreg_valid),
    .EX_result(ex_result), .EXreg_ld_ctrl(exreg_ld), .EXreg_rf_we(exreg_rf_we),
    .EXreg_res_from_mem(exreg_rfm), .EXreg_rf_waddr(exreg_waddr), .EXreg_pc(exreg_pc),
    .EX_bypass_waddr(byp_waddr), .EX_bypass_we(byp_we), .EX_bypass_result(byp_result),
    .EX_is_load(is_load)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:  return (a < b) ? 32'd1 : 32'd0;
      4'd4:  return a & b;
      4'd5:  return a | b;
      4'd6:  return ~(a | b);
      4'd7:  return a ^ b;
      4'd8:  return a << b[4:0];
      4'd9:  return a >> b[4:0];
      4'd10: return $signed(a) >>> b[4:0];
      4'd11: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] div_f(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (op[1]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000; r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b; r = a % b;
    end
    return DIV_ON ? (op[0] ? r : q) : 32'd0;
  endfunction

  // Model state: what sits in EX and how many cycles it has been there.
  logic  m_valid = 1'b0;
  inst_t m_inst = '0;
  int    m_age = 0;
  bit    started = 1'b0;

  function automatic bit m_rg();
    return !m_inst.div_en || !DIV_ON || (m_age >= 33);
  endfunction

  always @(posedge clk) begin
    started = 1'b1;
    if (!resetn) begin
      m_valid = 1'b0; m_inst = '0; m_age = 0;
    end else if (!m_valid || (m_rg() && mem_allow)) begin
      m_valid = id_valid;
      m_age   = 0;
      if (id_valid) m_inst = cur;
    end else begin
      m_age++;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic [31:0] e_alu, e_res;
      logic [3:0]  e_we;
      bit          rg, e_en;
      #2;
      rg    = m_rg();
      e_alu = alu_f(m_inst.alu_op, m_inst.src1, m_inst.src2);
      e_res = m_inst.div_en ? div_f(m_inst.div_op, m_inst.src1, m_inst.src2) : e_alu;
      e_en  = m_valid && rg && mem_allow && ((m_inst.ld != 0) || (m_inst.st != 0));
      e_we  = m_inst.st[2] ? 4'hF : m_inst.st[1] ? (e_alu[1] ? 4'hC : 4'h3) :
              m_inst.st[0] ? (4'h1 << e_alu[1:0]) : 4'h0;
      chk("allow_in", {31'b0, allow_in}, {31'b0, !m_valid || (rg && mem_allow)});
      chk("exreg_valid", {31'b0, exreg_valid}, {31'b0, m_valid && rg});
      chk("sram_en", {31'b0, sram_en}, {31'b0, e_en});
      chk("bypass_we", {31'b0, byp_we}, {31'b0, m_valid && m_inst.rf_we});
      chk("is_load", {31'b0, is_load}, {31'b0, m_valid && m_inst.rfm});
      if (m_valid) begin
        chk("exreg_pc", exreg_pc, m_inst.pc);
        chk("exreg_waddr", {27'b0, exreg_waddr}, {27'b0, m_inst.waddr});
        chk("bypass_waddr", {27'b0, byp_waddr}, {27'b0, m_inst.waddr});
        chk("exreg_ld", {27'b0, exreg_ld}, {27'b0, m_inst.ld});
        chk("exreg_flags", {30'b0, exreg_rf_we, exreg_rfm}, {30'b0, m_inst.rf_we, m_inst.rfm});
        if (rg) begin
          chk("ex_result", ex_result, e_res);
          chk("bypass_result", byp_result, e_res);
        end
      end
      if (e_en) chk("sram_addr", sram_addr, e_alu);
      if (e_en && m_inst.st != 0) begin
        chk("sram_we", {28'b0, sram_we}, {28'b0, e_we});
        chk("sram_wdata", sram_wdata, m_inst.st[0] ? {4{m_inst.rkd[7:0]}} :
            m_inst.st[1] ? {2{m_inst.rkd[15:0]}} : m_inst.rkd);
      end
    end
  end

  function automatic inst_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic de, input logic [1:0] dop);
    inst_t i = '0;
    i.alu_op = op; i.src1 = a; i.src2 = b; i.div_en = de; i.div_op = dop;
    i.rf_we = 1'b1; i.waddr = 5'd3; i.pc = 32'h1C00_0000;
    return i;
  endfunction

  // Issue one instruction with MEM open; report cycles from EX entry to EXreg_valid.
  task automatic issue(input inst_t i, output int lat, output logic [31:0] res);
    @(negedge clk);
    cur = i; id_valid = 1'b1; mem_allow = 1'b1;
    @(negedge clk);
    id_valid = 1'b0;
    lat = -1; res = 32'hDEAD_BEEF;
    for (int c = 0; c < 45; c++) begin
      #2;
      if (exreg_valid === 1'b1) begin lat = c; res = ex_result; break; end
      @(negedge clk);
    end
  endtask

  function automatic inst_t rand_inst();
    inst_t i;
    int k;
    i = '0;
    k = $urandom_range(0, 19);
    i.src1 = ($urandom_range(0, 1) != 0) ? $urandom() : $urandom_range(0, 40) - 20;
    i.src2 = ($urandom_range(0, 1) != 0) ? $urandom() : $urandom_range(0, 40) - 20;
    i.rkd = $urandom(); i.pc = $urandom(); i.waddr = 5'($urandom_range(0, 31));
    i.rf_we = 1'($urandom_range(0, 1));
    if (k == 0) begin
      i.div_en = 1'b1; i.div_op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: i.src2 = 32'd0;
        1: begin i.src1 = 32'h8000_0000; i.src2 = 32'hFFFF_FFFF; end
        default: ;
      endcase
    end else if (k <= 3) begin
      i.ld = 5'b00001 << $urandom_range(0, 4); i.rfm = 1'b1; i.rf_we = 1'b1;
    end else if (k <= 6) begin
      i.st = 3'b001 << $urandom_range(0, 2); i.rf_we = 1'b0;
    end else begin
      i.alu_op = 4'($urandom_range(0, 15));
    end
    return i;
  endfunction

  initial begin
    int lat, en_cnt, late;
    logic [31:0] res;
    inst_t i;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_allow_in", {31'b0, allow_in}, 32'd1);
    chk("rst_sram_en", {31'b0, sram_en}, 32'd0);
    chk("rst_exreg_valid", {31'b0, exreg_valid}, 32'd0);
    resetn = 1'b1;

    issue(mk(4'd0, 32'd5, 32'd7, 1'b0, 2'b00), lat, res);
    chk("add_lat", lat, 32'd0);
    chk("add_res", res, 32'd12);

    issue(mk(4'd0, -32'sd7, 32'd2, 1'b1, 2'b10), lat, res);
    chk("div_lat", lat, DIV_ON ? 32'd33 : 32'd0);
    chk("div_q", res, DIV_ON ? 32'hFFFF_FFFD : 32'd0);
    issue(mk(4'd0, -32'sd7, 32'd2, 1'b1, 2'b11), lat, res);
    chk("mod_r", res, DIV_ON ? 32'hFFFF_FFFF : 32'd0);
    issue(mk(4'd0, 32'd9, 32'd0, 1'b1, 2'b00), lat, res);
    chk("divu0_q", res, DIV_ON ? 32'hFFFF_FFFF : 32'd0);
    issue(mk(4'd0, 32'd9, 32'd0, 1'b1, 2'b01), lat, res);
    chk("modu0_r", res, DIV_ON ? 32'd9 : 32'd0);

    // st_b to 0x1003
    @(negedge clk);
    i = mk(4'd0, 32'h1000, 32'd3, 1'b0, 2'b00);
    i.st = 3'b001; i.rkd = 32'hAB; i.rf_we = 1'b0;
    cur = i; id_valid = 1'b1; mem_allow = 1'b1;
    @(negedge clk);
    id_valid = 1'b0;
    #2;
    chk("stb_we", {28'b0, sram_we}, 32'h8);
    chk("stb_wdata", sram_wdata, 32'hABAB_ABAB);
    en_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin @(negedge clk); #2; end
      if (sram_en === 1'b1) en_cnt++;
    end
    chk("stb_en_cycles", en_cnt, 32'd1);

    // Load held by MEM back-pressure for three cycles
    @(negedge clk);
    i = mk(4'd0, 32'h200, 32'd4, 1'b0, 2'b00);
    i.ld = 5'b10000; i.rfm = 1'b1;
    cur = i; id_valid = 1'b1; mem_allow = 1'b1;
    @(negedge clk);
    cur.src1 = 32'h300; mem_allow = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("stall_allow_in", {31'b0, allow_in}, 32'd0);
      chk("stall_sram_en", {31'b0, sram_en}, 32'd0);
      chk("stall_held_addr", ex_result, 32'h204);
      @(negedge clk);
    end
    mem_allow = 1'b1;
    #2;
    chk("release_sram_en", {31'b0, sram_en}, 32'd1);
    chk("release_addr", sram_addr, 32'h204);
    @(negedge clk);
    id_valid = 1'b0;

    // Reset in the middle of a division
    @(negedge clk);
    cur = mk(4'd0, 32'd100, 32'd7, 1'b1, 2'b00); id_valid = 1'b1;
    @(negedge clk);
    id_valid = 1'b0;
    repeat (11) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    late = 0;
    for (int c = 0; c < 40; c++) begin
      #2;
      if (exreg_valid !== 1'b0) late++;
      @(negedge clk);
    end
    chk("rst_mid_div_no_output", late, 32'd0);
    chk("rst_mid_div_allow_in", {31'b0, allow_in}, 32'd1);

    // Random traffic checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      resetn    = ($urandom_range(0, 199) != 0);
      id_valid  = ($urandom_range(0, 9) < 7);
      mem_allow = ($urandom_range(0, 9) < 8);
      cur       = rand_inst();
    end
    @(negedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
